lcd_page_cntrl: RTL
===================

LCD_PAGE_CNTRL -- requirements
Module: lcd_page_cntrl

Interface
REQ-001 Parameter: ROWS, 2, number of display rows (legal 1..4).
REQ-002 Parameter: COLS, 16, characters per row (legal 1..40; ROWS*COLS <= 80).
REQ-003 Port: Clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: Rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: Go  in  1  start one frame refresh; sampled only in S_IDLE.
REQ-006 Port: AutoRefresh  in  1  when high in S_IDLE, start a frame without Go.
REQ-007 Port: ClearFirst  in  1  when high at frame start, issue a clear before the frame is written.
REQ-008 Port: Display  in  ROWS*COLS*8  frame buffer; row 0 col 0 in MSB byte, row-major.
REQ-009 Port: DataValue  out  8  command/character byte to the 4-bit LCD driver.
REQ-010 Port: Command  out  1  1 = DataValue is a command, 0 = character data.
REQ-011 Port: Clear  out  1  clear-display request to the driver.
REQ-012 Port: Write  out  1  write request to the driver.
REQ-013 Port: Busy  in  1  driver busy.
REQ-014 Port: Ready  in  1  driver idle and accepting requests.
REQ-015 Port: Done  out  1  one-cycle pulse when a frame completes.
REQ-016 Port: Idle  out  1  high while in S_IDLE.

Function
REQ-017 The SHALL register all outputs; DataValue, Command, Clear, Write, Done default to 0 every cycle unless a state drives them.
REQ-018 The block SHALL start in S_INIT0, wait for Busy=1, then S_INIT1, wait for Busy=0, then enter S_IDLE (tracks the driver's power-up sequence).
REQ-019 In S_IDLE, Go=1 or AutoRefresh=1 SHALL latch Display and ClearFirst into internal registers, zero row/col counters, and go to S_CLR (if ClearFirst) else S_POS; Go and AutoRefresh together act as one start.
REQ-020 Go asserted outside S_IDLE SHALL be ignored (not queued); Display changes mid-frame SHALL NOT affect the frame in progress.
REQ-021 Driver handshake per transfer: assert request (Write or Clear) with stable DataValue/Command until Busy=1 (S_x_WAIT), keep asserted until Busy=0 (S_x_ACK), then deassert and wait for Ready=1 (S_x_DONE) before the next transfer.
REQ-022 S_CLR: Clear=1, Write=0; the clear handshake SHALL follow REQ-021, then go to S_POS.
REQ-023 S_POS: Command=1, Write=1, DataValue = 8'h80 | ROW_BASE[row]; after handshake go to S_CHR.
REQ-024 S_CHR: Command=0, Write=1, DataValue = latched byte (row*COLS+col); after handshake go to S_ITER.
REQ-025 S_ITER: col<COLS-1 -> col+1, S_CHR; col=COLS-1 and row<ROWS-1 -> col=0, row+1, S_POS; last char -> Done=1 for one cycle, S_IDLE.
REQ-026 Latency: start sampled at edge N SHALL produce Write=1 (or Clear=1) at edge N+1.
REQ-027 Counters SHALL be $clog2-sized, never exceed COLS-1/ROWS-1, and wrap only via REQ-025.
REQ-028 Idle SHALL be 1 only in S_IDLE; Write and Clear SHALL never be high in the same cycle.
REQ-029 Illegal ROWS/COLS SHALL cause an elaboration error.

Reset
REQ-030 Rst=1 SHALL immediately force all outputs to 0, counters and latched buffer to 0, state to S_INIT0, including mid-frame; no partial transfer resumes after reset.

Structure
REQ-031 Shared package lcd_pkg SHALL hold the state enumeration, LCD_SET_DDRAM = 8'h80, and ROW_BASE table {8'h00, 8'h40, 8'h14, 8'h54}.
REQ-032 One sub-module lcd_xfer_hs SHALL implement the REQ-021 request/Busy/Ready handshake, reused for clear, position and character transfers.

Verification (bench uses a behavioural driver model: Busy 3 cycles after request, 4 cycles high, Ready 2 cycles later)
REQ-033 Reset then model init pulse on Busy -> Idle=1, all outputs 0.
REQ-034 ROWS=2, COLS=16, Display "HELLO WORLD....." / "0123456789ABCDEF", Go pulse -> transfers 0x80, 16 chars, 0xC0, 16 chars in order, one Done pulse, Idle=1.
REQ-035 ClearFirst=1 with Go -> Clear handshake precedes 0x80; no Write during Clear.
REQ-036 ROWS=4, COLS=20 -> position commands 0x80, 0xC0, 0x94, 0xD4; 80 characters total.
REQ-037 Go re-pulsed mid-frame and Display changed mid-frame -> frame unchanged, no extra frame.
REQ-038 Rst asserted during a character transfer -> outputs 0 same cycle, returns via S_INIT0; AutoRefresh held high -> back-to-back frames with Done per frame.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD page-controller types and HD44780 DDRAM addressing constants.
// Row base addresses follow the common 4-line panel layout.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT0, S_INIT1, S_IDLE, S_CLR, S_POS, S_CHR, S_ITER
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE, HS_WAIT, HS_ACK, HS_DONE
  } hs_state_t;

  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] ROW_BASE [4]  = '{8'h00, 8'h40, 8'h14, 8'h54};

  function automatic logic [7:0] pos_cmd(input logic [1:0] row);
    return LCD_SET_DDRAM | ROW_BASE[row];
  endfunction

endpackage

// File: rtl/lcd_xfer_hs.sv
// One request/Busy/Ready transfer to the LCD driver; request appears the edge after start_i.
// Request held until Busy rises then falls; done_o pulses once Ready returns.
module lcd_xfer_hs
  import lcd_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start_i,
  input  logic       clr_i,
  input  logic       cmd_i,
  input  logic [7:0] dat_i,
  input  logic       Busy,
  input  logic       Ready,
  output logic [7:0] DataValue,
  output logic       Command,
  output logic       Clear,
  output logic       Write,
  output logic       done_o
);

  hs_state_t  hs_q;
  logic [7:0] dat_q;
  logic       cmd_q, clr_q, wr_q, done_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hs_q   <= HS_IDLE;
      dat_q  <= '0;
      cmd_q  <= 1'b0;
      clr_q  <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (hs_q)
        HS_IDLE: if (start_i) begin
          dat_q <= dat_i;
          cmd_q <= cmd_i;
          clr_q <= clr_i;
          wr_q  <= ~clr_i;
          hs_q  <= HS_WAIT;
        end
        HS_WAIT: if (Busy) hs_q <= HS_ACK;
        HS_ACK: if (!Busy) begin
          dat_q <= '0;
          cmd_q <= 1'b0;
          clr_q <= 1'b0;
          wr_q  <= 1'b0;
          hs_q  <= HS_DONE;
        end
        HS_DONE: if (Ready) begin
          done_q <= 1'b1;
          hs_q   <= HS_IDLE;
        end
        default: hs_q <= HS_IDLE;
      endcase
    end
  end

  assign DataValue = dat_q;
  assign Command   = cmd_q;
  assign Clear     = clr_q;
  assign Write     = wr_q;
  assign done_o    = done_q;

endmodule

// File: rtl/lcd_page_cntrl.sv
// Walks a latched ROWSxCOLS frame into the LCD driver: optional clear, then per row a
// DDRAM position command and COLS characters. First request one edge after start; paced by Busy/Ready.
module lcd_page_cntrl
  import lcd_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 16
)
(
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Go,
  input  logic                   AutoRefresh,
  input  logic                   ClearFirst,
  input  logic [ROWS*COLS*8-1:0] Display,
  output logic [7:0]             DataValue,
  output logic                   Command,
  output logic                   Clear,
  output logic                   Write,
  input  logic                   Busy,
  input  logic                   Ready,
  output logic                   Done,
  output logic                   Idle
);

  localparam int NB = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  generate
    if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 40 || NB > 80) begin : g_bad_geom
      $error("lcd_page_cntrl: illegal ROWS/COLS geometry");
    end
  endgenerate

  state_t        state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [7:0]    chars_q [NB];
  logic          start_q, xclr_q, xcmd_q, done_q, idle_q;
  logic [7:0]    xdat_q;
  logic          hs_done;
  logic [IW-1:0] chr_idx;

  // Row-major layout means the character after the current one is always chr_idx+1.
  assign chr_idx = IW'(int'(row_q) * COLS + int'(col_q));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_INIT0;
      row_q   <= '0;
      col_q   <= '0;
      start_q <= 1'b0;
      xclr_q  <= 1'b0;
      xcmd_q  <= 1'b0;
      xdat_q  <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b0;
      for (int i = 0; i < NB; i++) chars_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_INIT0: if (Busy) state_q <= S_INIT1;
        S_INIT1: if (!Busy) begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
        end
        S_IDLE: if (Go || AutoRefresh) begin
          for (int i = 0; i < NB; i++) chars_q[i] <= Display[(NB-1-i)*8 +: 8];
          row_q   <= '0;
          col_q   <= '0;
          idle_q  <= 1'b0;
          start_q <= 1'b1;
          xcmd_q  <= 1'b1;
          xclr_q  <= ClearFirst;
          xdat_q  <= ClearFirst ? LCD_CLEAR : pos_cmd(2'd0);
          state_q <= ClearFirst ? S_CLR : S_POS;
        end
        S_CLR: if (hs_done) begin
          start_q <= 1'b1;
          xclr_q  <= 1'b0;
          xcmd_q  <= 1'b1;
          xdat_q  <= pos_cmd(2'(row_q));
          state_q <= S_POS;
        end
        S_POS: if (hs_done) begin
          start_q <= 1'b1;
          xcmd_q  <= 1'b0;
          xdat_q  <= chars_q[chr_idx];
          state_q <= S_CHR;
        end
        S_CHR: if (hs_done) state_q <= S_ITER;
        S_ITER: begin
          if (col_q != COL_LAST) begin
            col_q   <= col_q + CW'(1);
            start_q <= 1'b1;
            xcmd_q  <= 1'b0;
            xdat_q  <= chars_q[chr_idx + IW'(1)];
            state_q <= S_CHR;
          end else if (row_q != ROW_LAST) begin
            col_q   <= '0;
            row_q   <= row_q + RW'(1);
            start_q <= 1'b1;
            xcmd_q  <= 1'b1;
            xdat_q  <= pos_cmd(2'(row_q) + 2'd1);
            state_q <= S_POS;
          end else begin
            done_q  <= 1'b1;
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_INIT0;
      endcase
    end
  end

  lcd_xfer_hs u_xfer_hs (
    .Clk      (Clk),
    .Rst      (Rst),
    .start_i  (start_q),
    .clr_i    (xclr_q),
    .cmd_i    (xcmd_q),
    .dat_i    (xdat_q),
    .Busy     (Busy),
    .Ready    (Ready),
    .DataValue(DataValue),
    .Command  (Command),
    .Clear    (Clear),
    .Write    (Write),
    .done_o   (hs_done)
  );

  assign Done = done_q;
  assign Idle = idle_q;

endmodule
